// File: rtl/alu_pkg.sv
// Shared encodings for the sequential add/sub unit: opcodes, FSM states and
// the operand-mapping helpers used at accept time.
package alu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_ADC = 2'b10;
   localparam logic [1:0] OP_SBB = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   // Subtracting ops add the one's complement of b.
   function automatic logic op_inverts_b(input logic [1:0] op);
      return (op == OP_SUB) || (op == OP_SBB);
   endfunction

   function automatic logic op_carry0(input logic [1:0] op, input logic cin);
      logic c0;
      case (op)
         OP_ADD:  c0 = 1'b0;
         OP_SUB:  c0 = 1'b1;
         OP_ADC:  c0 = cin;
         default: c0 = ~cin;
      endcase
      return c0;
   endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational SLICE-bit adder; also reports the carry into its top bit so
// the caller can derive signed overflow on the final slice.
module addsub_slice #(
   parameter int unsigned SLICE = 8
) (
   input  logic [SLICE-1:0] x,
   input  logic [SLICE-1:0] y,
   input  logic             ci,
   output logic [SLICE-1:0] s,
   output logic             co,
   output logic             c_msb_in
);

   always_comb begin
      {co, s}  = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, ci};
      // Sum bit = x ^ y ^ carry-in, so the top carry-in falls out directly.
      c_msb_in = s[SLICE-1] ^ x[SLICE-1] ^ y[SLICE-1];
   end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract: one SLICE-bit chunk per cycle, LSB first, with a
// registered carry chain and valid/ready handshakes on both sides.
module addsub_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             zero
);

   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             c_q;
   logic             zacc_q;

   logic [SLICE-1:0] x, y, s;
   logic             co, c_msb_in, zacc;

   always_comb begin
      x    = a_q[int'(cnt) * SLICE +: SLICE];
      y    = b_q[int'(cnt) * SLICE +: SLICE];
      zacc = (s == '0) & ((cnt == '0) | zacc_q);
   end

   addsub_slice #(
      .SLICE (SLICE)
   ) u_slice (
      .x        (x),
      .y        (y),
      .ci       (c_q),
      .s        (s),
      .co       (co),
      .c_msb_in (c_msb_in)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         c_q       <= 1'b0;
         zacc_q    <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_q      <= a;
                  b_q      <= op_inverts_b(op) ? ~b : b;
                  c_q      <= op_carry0(op, cin);
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= S_RUN;
               end
            end
            S_RUN: begin
               result[int'(cnt) * SLICE +: SLICE] <= s;
               c_q    <= co;
               zacc_q <= zacc;
               if (cnt == LAST) begin
                  carry     <= co;
                  overflow  <= c_msb_in ^ co;
                  zero      <= zacc;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
- Multi-cycle, parametrised add/subtract unit; successor to the combinational WIDTH-bit add/sub block.
- Processes WIDTH-bit operands in SLICE-bit chunks, LSB chunk first, over WIDTH/SLICE cycles with a registered carry chain.
- Adds carry-in/borrow-in modes for multi-precision arithmetic and valid/ready handshakes on input and output.
- Sits between the operand register stage and the writeback stage of the datapath.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of SLICE.
- SLICE, 8, bits processed per cycle; SLICE == WIDTH gives single-cycle RUN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and op valid.
- in_ready  out  1  unit can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  2  00 ADD, 01 SUB, 10 ADC (A+B+cin), 11 SBB (A-B-cin).
- cin  in  1  carry-in (ADC) or borrow-in (SBB); ignored for ADD/SUB.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  sum/difference, modulo 2^WIDTH.
- carry  out  1  raw carry-out of A + B' + c0 (for SUB/SBB: 1 = no borrow).
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  result == 0.

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high.
- Reset: state IDLE; in_ready=1, out_valid=0, result=0, carry=0, overflow=0, zero=0; slice counter=0.
- Operand mapping: B' = b for ADD/ADC, ~b for SUB/SBB. c0 = 0 for ADD, 1 for SUB, cin for ADC, ~cin for SBB.
- IDLE: in_ready=1. On in_valid & in_ready, capture a, B', c0 and op; clear counter; go to RUN. Nothing else changes state here.
- RUN: in_ready=0. Each cycle, add slice k of A and B' plus the registered carry. Write the sum into result slice k and register the slice carry-out. Accumulate zero as AND of slice-zero flags.
  - On the last slice (k = WIDTH/SLICE-1), compute overflow from the MSB carries and set carry to the final carry-out; go to DONE.
- DONE: out_valid=1; result and flags held stable. On out_ready, clear out_valid and return to IDLE.
- Latency: from accept edge to out_valid high is exactly WIDTH/SLICE cycles. Throughput is one operation per WIDTH/SLICE+2 cycles when out_ready is held high.
- Backpressure: out_ready low holds DONE indefinitely; no outputs change; in_valid is ignored.
- in_valid while busy (RUN/DONE): ignored; no capture. The producer must hold in_valid until in_ready is seen.
- Inputs a/b/op/cin may change freely after the accept edge; the unit uses only the captured copies.
- Outputs during RUN: result/flags are not valid; the bench samples only on out_valid.
- Reset mid-operation: rst asserted in RUN or DONE aborts immediately to reset values; the partial result is discarded.
- Wrap-around: result is modulo 2^WIDTH; e.g. FF+01 gives 00, carry=1, zero=1.

Decomposition:
- Package alu_pkg: op encoding constants (OP_ADD, OP_SUB, OP_ADC, OP_SBB) and FSM state encoding (S_IDLE, S_RUN, S_DONE).
- Sub-module addsub_slice: combinational SLICE-bit adder with inputs x, y, ci and outputs s, co, and c_msb_in (carry into the top bit, used for overflow). Instantiated once and time-multiplexed across slices.
- Top level holds the FSM, counter, operand/result shift registers and flag registers.

Test Plan (WIDTH=8, SLICE=4):
- Basic add and subtract:
  - ADD a=01 b=01 -> result=02, carry=0, overflow=0, zero=0; out_valid exactly 2 cycles after accept.
  - SUB a=01 b=01 -> result=00, carry=1, zero=1, overflow=0.
  - SUB a=00 b=01 -> result=FF, carry=0, overflow=0, zero=0.
- Signed overflow: ADD a=7F b=01 -> result=80, overflow=1, carry=0. SUB a=80 b=01 -> result=7F, overflow=1, carry=1.
- Carry/borrow-in modes: ADC a=FF b=00 cin=1 -> result=00, carry=1, zero=1. SBB a=05 b=02 cin=1 -> result=02, carry=1.
- Backpressure: complete an op with out_ready=0 for 5 cycles while in_valid=1 with new operands -> result/flags stable, in_ready=0. After out_ready=1, one cycle in DONE then IDLE; the new op is accepted next and its result is correct.
- Reset mid-op: assert rst one cycle after accept -> immediately out_valid=0, in_ready=1, result=00; a following ADD 03+04 yields 07.
